// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package pc_fetch_unit_pkg;

  // Instruction presented to decode while nothing valid has been fetched.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Sequential fetch stride in bytes.
  localparam int unsigned PC_INC = 4;

  // Low address bits that must be zero for a word-aligned fetch.
  localparam int unsigned ALIGN_MASK = 3;

  // Width of the J-type instr_index field.
  localparam int unsigned JUMP_IDX_W = 26;

  // FETCH: normal operation. DRAIN: a redirect arrived while a request was outstanding;
  // wait for that ack, throw the data away, then continue from the pending target.
  typedef enum logic {
    StFetch = 1'b0,
    StDrain = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Redirect priority and target formation. Purely combinational.
module pc_fetch_unit_next_pc_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  jump_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_W-1:0]     branch_target_i,
  input  logic [ADDR_W-1:0]     pc_next_i,
  input  logic [JUMP_IDX_W-1:0] jump_index_i,
  output logic                  redirect_o,
  output logic [ADDR_W-1:0]     target_o
);

  // Jump keeps the 256 MB region of the delay-slot PC (top four bits of PcNext).
  localparam logic [ADDR_W-1:0] RegionMask = {4'hF, {(ADDR_W - 4){1'b0}}};
  localparam logic [ADDR_W-1:0] WordMask   = ~ADDR_W'(ALIGN_MASK);

  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;

  // Form both candidate targets and pick one; jump wins when both are asserted.
  always_comb begin
    jump_target   = (pc_next_i & RegionMask) | ADDR_W'({jump_index_i, 2'b00});
    branch_target = branch_target_i & WordMask;
    redirect_o    = jump_i | branch_taken_i;
    target_o      = jump_i ? jump_target : branch_target;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues imem requests and holds the IF/ID outputs.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  BranchTaken,
  input  logic [ADDR_W-1:0]     BranchTarget,
  input  logic                  Jump,
  input  logic [JUMP_IDX_W-1:0] JumpIndex,
  output logic                  ImemReq,
  output logic [ADDR_W-1:0]     ImemAddr,
  input  logic                  ImemAck,
  input  logic [DATA_W-1:0]     ImemRdata,
  output logic                  InstrValid,
  output logic [DATA_W-1:0]     Instr,
  output logic [ADDR_W-1:0]     PcOut,
  output logic [ADDR_W-1:0]     PcNext
);

  localparam logic [ADDR_W-1:0] ResetPcAligned = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] PcInc          = ADDR_W'(PC_INC);
  localparam logic [DATA_W-1:0] NopInstr       = DATA_W'(NOP_INSTR);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;
  logic              instr_valid_q, instr_valid_d;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              slot_free;
  logic              imem_req;
  logic              ack;

  pc_fetch_unit_next_pc_sel #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_sel (
    .jump_i         (Jump),
    .branch_taken_i (BranchTaken),
    .branch_target_i(BranchTarget),
    .pc_next_i      (pc_next_q),
    .jump_index_i   (JumpIndex),
    .redirect_o     (redirect),
    .target_o       (target)
  );

  // Request generation; an ack is only meaningful while a request is up.
  always_comb begin
    slot_free = ~instr_valid_q | ~Stall;
    imem_req  = ~reset & (((state_q == StFetch) & slot_free) | (state_q == StDrain));
    ack       = imem_req & ImemAck;
  end

  // Next-state for the FSM, fetch/pending PCs and the decode-facing output registers.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    pc_next_d     = pc_next_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          // Redirect beats Stall: whatever decode holds is flushed.
          instr_valid_d = 1'b0;
          if (imem_req && !ImemAck) begin
            // Address must stay stable until the old request completes.
            state_d   = StDrain;
            pend_pc_d = target;
          end else begin
            fetch_pc_d = target;
          end
        end else if (ack) begin
          instr_d       = ImemRdata;
          pc_out_d      = fetch_pc_q;
          pc_next_d     = fetch_pc_q + PcInc;
          instr_valid_d = 1'b1;
          fetch_pc_d    = fetch_pc_q + PcInc;
        end else if (!Stall) begin
          instr_valid_d = 1'b0;
        end
      end
      StDrain: begin
        instr_valid_d = 1'b0;
        if (redirect) begin
          pend_pc_d = target;
        end
        if (ack) begin
          // Drained data is dropped; the newest target wins.
          fetch_pc_d = redirect ? target : pend_pc_q;
          state_d    = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetch;
      fetch_pc_q    <= ResetPcAligned;
      pend_pc_q     <= ResetPcAligned;
      instr_q       <= NopInstr;
      pc_out_q      <= ResetPcAligned;
      pc_next_q     <= ResetPcAligned + PcInc;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      pc_next_q     <= pc_next_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign ImemReq    = imem_req;
  assign ImemAddr   = fetch_pc_q;
  assign InstrValid = instr_valid_q;
  assign Instr      = instr_q;
  assign PcOut      = pc_out_q;
  assign PcNext     = pc_next_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a delivery scoreboard on the main instance.
module tb_pc_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk;

  // Main instance (RESET_PC = 0)
  logic        reset, Stall, BranchTaken, Jump, ImemAck, ImemReq, InstrValid;
  logic [31:0] BranchTarget, ImemAddr, ImemRdata, Instr, PcOut, PcNext;
  logic [25:0] JumpIndex;
  logic        zw, man_ack;

  // Wrap-around instance (RESET_PC = FFFF_FFF8)
  logic        rst1, br1, ack1, req1, iv1, zw1, man_ack1;
  logic [31:0] bt1, addr1, rdata1, instr1, pcout1, pcnext1;

  int tests;
  int fails;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  // Imem models: zero-wait ack follows request; data is a function of address.
  assign ImemAck   = zw ? ImemReq : man_ack;
  assign ImemRdata = ImemAddr ^ KEY;
  assign ack1      = zw1 ? req1 : man_ack1;
  assign rdata1    = addr1 ^ KEY;

  pc_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump        (Jump),
    .JumpIndex   (JumpIndex),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemAck     (ImemAck),
    .ImemRdata   (ImemRdata),
    .InstrValid  (InstrValid),
    .Instr       (Instr),
    .PcOut       (PcOut),
    .PcNext      (PcNext)
  );

  pc_fetch_unit #(
    .RESET_PC(32'hFFFF_FFF8)
  ) dut1 (
    .clk         (clk),
    .reset       (rst1),
    .Stall       (1'b0),
    .BranchTaken (br1),
    .BranchTarget(bt1),
    .Jump        (1'b0),
    .JumpIndex   (26'h0),
    .ImemReq     (req1),
    .ImemAddr    (addr1),
    .ImemAck     (ack1),
    .ImemRdata   (rdata1),
    .InstrValid  (iv1),
    .Instr       (instr1),
    .PcOut       (pcout1),
    .PcNext      (pcnext1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Settle, retire the instruction decode consumes this cycle, move to the next negedge.
  task automatic cyc();
    #1;
    if (InstrValid === 1'b1 && Stall === 1'b0) begin
      tests++;
      assert (sb.size() != 0)
      else begin
        fails++;
        $error("FAIL sb_unexpected observed pc=%h expected=no delivery", PcOut);
      end
      if (sb.size() != 0) begin
        exp_pc = sb.pop_front();
        chk("sb_instr", Instr, exp_pc ^ KEY);
        chk("sb_pcout", PcOut, exp_pc);
        chk("sb_pcnext", PcNext, exp_pc + 32'd4);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    Jump = 1'b0; JumpIndex = '0; zw = 1'b1; man_ack = 1'b0;
    rst1 = 1'b1; br1 = 1'b0; bt1 = '0; zw1 = 1'b1; man_ack1 = 1'b0;
    @(negedge clk);
    cyc();

    // Reset state
    chk1("rst_req", ImemReq, 1'b0);
    chk1("rst_valid", InstrValid, 1'b0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_pcout", PcOut, 32'h0);
    chk("rst_pcnext", PcNext, 32'h4);
    chk("rst_addr", ImemAddr, 32'h0);
    chk("rst1_addr", addr1, 32'hFFFF_FFF8);
    chk("rst1_pcnext", pcnext1, 32'hFFFF_FFFC);

    // 1: zero-wait streaming
    reset = 1'b0;
    sb.push_back(32'h0);
    #1;
    chk1("t1_req0", ImemReq, 1'b1);
    chk("t1_addr0", ImemAddr, 32'h0);
    cyc();
    chk("t1_addr1", ImemAddr, 32'h4);
    chk1("t1_valid", InstrValid, 1'b1);
    sb.push_back(32'h4);
    cyc();
    chk("t1_addr2", ImemAddr, 32'h8);
    sb.push_back(32'h8);
    cyc();

    // 2: stall holds outputs, no request
    Stall = 1'b1;
    #1;
    chk1("t2_req", ImemReq, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_pcout", PcOut, 32'h8);
      chk("t2_addr", ImemAddr, 32'hC);
    end
    Stall = 1'b0;
    sb.push_back(32'hC);
    #1;
    chk1("t2_req_resume", ImemReq, 1'b1);
    chk("t2_addr_resume", ImemAddr, 32'hC);
    cyc();

    // 3: branch with same-cycle ack; target low bits dropped
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0111;
    cyc();
    BranchTaken = 1'b0;
    chk("t3_addr", ImemAddr, 32'h0000_0110);
    chk1("t3_bubble", InstrValid, 1'b0);
    sb.push_back(32'h0000_0110);
    cyc();
    chk("t3_pcout", PcOut, 32'h0000_0110);

    // 4: branch while request outstanding -> drain
    zw = 1'b0; man_ack = 1'b0;
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0200;
    cyc();
    BranchTaken = 1'b0;
    chk1("t4_req_drain", ImemReq, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("t4_addr_hold", ImemAddr, 32'h0000_0114);
      cyc();
    end
    chk("t4_addr_hold", ImemAddr, 32'h0000_0114);
    man_ack = 1'b1;
    cyc();
    zw = 1'b1; man_ack = 1'b0;
    chk("t4_addr_target", ImemAddr, 32'h0000_0200);
    chk1("t4_no_valid", InstrValid, 1'b0);
    sb.push_back(32'h0000_0200);
    cyc();

    // 5: jump, then jump+branch together
    BranchTaken = 1'b1; BranchTarget = 32'h4000_0004;
    cyc();
    BranchTaken = 1'b0;
    chk("t5_addr_pre", ImemAddr, 32'h4000_0004);
    sb.push_back(32'h4000_0004);
    cyc();
    chk("t5_pcnext", PcNext, 32'h4000_0008);
    Jump = 1'b1; JumpIndex = 26'h000_0040;
    cyc();
    Jump = 1'b0;
    chk("t5_jump_addr", ImemAddr, 32'h4000_0100);
    chk1("t5_jump_bubble", InstrValid, 1'b0);
    sb.push_back(32'h4000_0100);
    cyc();
    Jump = 1'b1; JumpIndex = 26'h000_0080;
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0300;
    cyc();
    Jump = 1'b0; BranchTaken = 1'b0;
    chk("t5_prio_addr", ImemAddr, 32'h4000_0200);
    sb.push_back(32'h4000_0200);
    cyc();

    // Redirect overrides stall: held instruction is flushed, never consumed
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h0000_0503;
    void'(sb.pop_front());
    cyc();
    Stall = 1'b0; BranchTaken = 1'b0;
    chk1("t5_stall_flush", InstrValid, 1'b0);
    chk("t5_stall_addr", ImemAddr, 32'h0000_0500);
    sb.push_back(32'h0000_0500);
    cyc();
    reset = 1'b1;
    cyc();
    chk1("t5_reset_valid", InstrValid, 1'b0);
    chk("t5_sb_empty", 32'(sb.size()), 32'h0);

    // 6: wrap-around and reset during drain
    rst1 = 1'b0;
    #1;
    chk1("t6_req", req1, 1'b1);
    chk("t6_addr0", addr1, 32'hFFFF_FFF8);
    cyc();
    chk("t6_addr1", addr1, 32'hFFFF_FFFC);
    chk("t6_instr", instr1, 32'hFFFF_FFF8 ^ KEY);
    chk("t6_pcout", pcout1, 32'hFFFF_FFF8);
    cyc();
    chk("t6_addr2", addr1, 32'h0000_0000);
    chk("t6_pcnext_wrap", pcnext1, 32'h0000_0000);
    zw1 = 1'b0; man_ack1 = 1'b0; br1 = 1'b1; bt1 = 32'h0000_1000;
    cyc();
    br1 = 1'b0;
    chk1("t6_drain_req", req1, 1'b1);
    chk("t6_drain_addr", addr1, 32'h0000_0000);
    rst1 = 1'b1;
    cyc();
    chk1("t6_rst_req", req1, 1'b0);
    chk1("t6_rst_valid", iv1, 1'b0);
    chk("t6_rst_addr", addr1, 32'hFFFF_FFF8);
    rst1 = 1'b0; zw1 = 1'b1;
    cyc();
    chk1("t6_restart_valid", iv1, 1'b1);
    chk("t6_restart_pcout", pcout1, 32'hFFFF_FFF8);
    chk("t6_restart_addr", addr1, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
